acq_sequencer: RTL and testbench
================================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter ARM_CYCLES, default 16: cycles the acquisition datapath is held in reset before each run.
REQ-002 Parameter DRAIN_CYCLES, default 4096: maximum cycles spent waiting for the closing tlast after a stop.
REQ-003 master_clock  in  1  sole clock, 40 MHz; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_start, cmd_stop  in  1 each  single-cycle software command pulses.
REQ-006 cfg_num_blocks  in  16  tlast-terminated blocks per run; 0 = continuous until stop.
REQ-007 cfg_packets  in  16, cfg_raw_mode  in  1: packet count and raw/processed mode for the datapath.
REQ-008 cfg_pulse_period, cfg_pulse_high  in  32 each: sensor start-pulse period and high time, in master_clock cycles.
REQ-009 cfg_timeout  in  32  watchdog limit in cycles; 0 disables the watchdog.
REQ-010 mon_tvalid, mon_tready, mon_tlast  in  1 each: passive tap of the datapath AXIS output.
REQ-011 acq_resetn  out  1  datapath active-low enable.
REQ-012 acq_number_of_packet  out  16, acq_send_raw  out  1: latched copies of cfg_packets and cfg_raw_mode.
REQ-013 acq_pulse_period, acq_pulse_high  out  32 each: latched copies of the pulse configuration.
REQ-014 busy  out  1, done  out  1 (pulse), cfg_err  out  1 (pulse), timeout_err  out  1 (sticky).
REQ-015 block_count  out  16  tlast beats accepted in the current run; state  out  3  current state encoding.

Function
REQ-016 States SHALL be IDLE=0, ARM=1, RUN=2, DRAIN=3, DONE=4, ERROR=5; all outputs registered.
REQ-017 Beat = mon_tvalid & mon_tready; tlast beat = beat & mon_tlast.
REQ-018 IDLE: acq_resetn=0, busy=0; on cmd_start with cfg_pulse_high>0 and cfg_pulse_period>cfg_pulse_high:
- latch all cfg_* into acq_* and internal copies;
- clear block_count and timeout_err;
- go to ARM.
REQ-019 IDLE, cmd_start with invalid pulse config: cfg_err=1 for one cycle, no latch, stay IDLE.
REQ-020 cmd_start and cmd_stop in the same IDLE cycle: stop wins; nothing is latched.
REQ-021 ARM: acq_resetn=0, busy=1, for exactly ARM_CYCLES cycles; then RUN, with acq_resetn=1 on the first RUN cycle.
REQ-022 cmd_stop in ARM: go directly to DONE.
REQ-023 RUN, each tlast beat: block_count+1, saturating at 0xFFFF.
REQ-024 RUN, tlast beat raising block_count to latched num_blocks (nonzero): go to DONE.
REQ-025 RUN, cmd_stop: go to DRAIN. If the same cycle is the completing tlast beat, REQ-024 wins.
REQ-026 Watchdog (RUN and DRAIN): counter cleared on any beat and on state entry, else incremented.
- counter reaching latched timeout (nonzero) with no beat that cycle: set timeout_err, go to ERROR;
- a beat in the same cycle clears the counter; no error.
REQ-027 DRAIN: acq_resetn stays 1; next tlast beat (counted) or DRAIN_CYCLES elapsed -> DONE.
REQ-028 DONE: one cycle; done=1, acq_resetn=0, busy=0; then IDLE.
REQ-029 ERROR: acq_resetn=0, busy=0, timeout_err=1; cmd_stop -> IDLE; cmd_start ignored.
REQ-030 acq_* configuration outputs SHALL change only on an accepted start; cfg_* changes during a run have no effect.
REQ-031 cmd_start outside IDLE SHALL be ignored.

Reset
REQ-032 reset in any state, including mid-run: next cycle state=IDLE and:
- acq_resetn=0, busy=0, done=0, cfg_err=0, timeout_err=0;
- block_count=0, watchdog=0;
- acq_pulse_period=0, acq_pulse_high=0, acq_number_of_packet=0, acq_send_raw=0.
REQ-033 reset SHALL take priority over every command and monitor input in the same cycle.

Verification
REQ-034 Scenario: cfg_num_blocks=2, period=400, high=40, start, two tlast beats -> acq_resetn rises ARM_CYCLES cycles after start; done after 2nd tlast; block_count=2; acq_resetn=0.
REQ-035 Scenario: start with high=0 -> cfg_err one cycle, state stays 0, acq_* stay 0.
REQ-036 Scenario: cfg_timeout=100, no beats in RUN -> timeout_err=1, state=5 at 100 cycles; cmd_stop -> IDLE; next start clears timeout_err.
REQ-037 Scenario: cfg_num_blocks=0, cmd_stop mid-run, tlast 10 cycles later -> DRAIN then done, block_count incremented; with no tlast, done after DRAIN_CYCLES.
REQ-038 Scenario: cmd_stop coincident with the completing tlast beat -> direct DONE, no DRAIN cycle.
REQ-039 Scenario: reset asserted in RUN with block_count=5 -> all REQ-032 values next cycle; cfg_* change during run leaves acq_* unchanged.

Source files
------------

// File: rtl/acq_sequencer.sv
// Acquisition run sequencer: arms the datapath, counts tlast-terminated blocks,
// drains on stop and guards the stream with a watchdog.
module acq_sequencer #(
  parameter int unsigned ARM_CYCLES   = 16,
  parameter int unsigned DRAIN_CYCLES = 4096
) (
  input  logic        master_clock,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic [15:0] cfg_num_blocks,
  input  logic [15:0] cfg_packets,
  input  logic        cfg_raw_mode,
  input  logic [31:0] cfg_pulse_period,
  input  logic [31:0] cfg_pulse_high,
  input  logic [31:0] cfg_timeout,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic        mon_tlast,
  output logic        acq_resetn,
  output logic [15:0] acq_number_of_packet,
  output logic        acq_send_raw,
  output logic [31:0] acq_pulse_period,
  output logic [31:0] acq_pulse_high,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic        timeout_err,
  output logic [15:0] block_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t      cur, nxt;
  logic [31:0] arm_cnt, arm_cnt_n;
  logic [31:0] drain_cnt, drain_cnt_n;
  logic [31:0] wd_cnt, wd_cnt_n;
  logic [15:0] num_blocks_q;
  logic [31:0] timeout_q;
  logic [15:0] block_count_n;
  logic        timeout_err_n;
  logic        cfg_err_n;
  logic        accept;
  logic        beat;
  logic        tlast_beat;
  logic [15:0] count_inc;
  logic        complete;
  logic        wd_expire;

  assign beat       = mon_tvalid & mon_tready;
  assign tlast_beat = beat & mon_tlast;
  assign count_inc  = (block_count == '1) ? block_count : block_count + 16'd1;
  assign complete   = tlast_beat && (num_blocks_q != '0) && (count_inc == num_blocks_q);
  // Expiry is judged on the value the counter would reach this cycle, so a beat wins.
  assign wd_expire  = !beat && (timeout_q != '0) && ((wd_cnt + 32'd1) == timeout_q);

  always_comb begin
    nxt           = cur;
    arm_cnt_n     = '0;
    drain_cnt_n   = '0;
    wd_cnt_n      = '0;
    block_count_n = block_count;
    timeout_err_n = timeout_err;
    cfg_err_n     = 1'b0;
    accept        = 1'b0;
    case (cur)
      S_IDLE: begin
        if (cmd_start && !cmd_stop) begin
          if ((cfg_pulse_high != '0) && (cfg_pulse_period > cfg_pulse_high)) begin
            accept        = 1'b1;
            block_count_n = '0;
            timeout_err_n = 1'b0;
            nxt           = S_ARM;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (cmd_stop) begin
          nxt = S_DONE;
        end else if (arm_cnt == 32'(ARM_CYCLES - 1)) begin
          nxt = S_RUN;
        end else begin
          arm_cnt_n = arm_cnt + 32'd1;
        end
      end
      S_RUN: begin
        wd_cnt_n = beat ? '0 : wd_cnt + 32'd1;
        if (tlast_beat) block_count_n = count_inc;
        if (complete) begin
          nxt = S_DONE;
        end else if (wd_expire) begin
          nxt           = S_ERROR;
          timeout_err_n = 1'b1;
        end else if (cmd_stop) begin
          nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        wd_cnt_n    = beat ? '0 : wd_cnt + 32'd1;
        drain_cnt_n = drain_cnt + 32'd1;
        if (tlast_beat) begin
          block_count_n = count_inc;
          nxt           = S_DONE;
        end else if (wd_expire) begin
          nxt           = S_ERROR;
          timeout_err_n = 1'b1;
        end else if (drain_cnt == 32'(DRAIN_CYCLES - 1)) begin
          nxt = S_DONE;
        end
      end
      S_DONE:  nxt = S_IDLE;
      S_ERROR: if (cmd_stop) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (nxt != cur) wd_cnt_n = '0;
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      cur                  <= S_IDLE;
      arm_cnt              <= '0;
      drain_cnt            <= '0;
      wd_cnt               <= '0;
      block_count          <= '0;
      timeout_err          <= 1'b0;
      cfg_err              <= 1'b0;
      done                 <= 1'b0;
      busy                 <= 1'b0;
      acq_resetn           <= 1'b0;
      num_blocks_q         <= '0;
      timeout_q            <= '0;
      acq_number_of_packet <= '0;
      acq_send_raw         <= 1'b0;
      acq_pulse_period     <= '0;
      acq_pulse_high       <= '0;
    end else begin
      cur         <= nxt;
      arm_cnt     <= arm_cnt_n;
      drain_cnt   <= drain_cnt_n;
      wd_cnt      <= wd_cnt_n;
      block_count <= block_count_n;
      timeout_err <= timeout_err_n;
      cfg_err     <= cfg_err_n;
      done        <= (nxt == S_DONE);
      busy        <= (nxt == S_ARM) || (nxt == S_RUN) || (nxt == S_DRAIN);
      acq_resetn  <= (nxt == S_RUN) || (nxt == S_DRAIN);
      if (accept) begin
        num_blocks_q         <= cfg_num_blocks;
        timeout_q            <= cfg_timeout;
        acq_number_of_packet <= cfg_packets;
        acq_send_raw         <= cfg_raw_mode;
        acq_pulse_period     <= cfg_pulse_period;
        acq_pulse_high       <= cfg_pulse_high;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed self-checking bench for acq_sequencer (ARM_CYCLES=4, DRAIN_CYCLES=20).
`timescale 1ns/1ps
module tb_acq_sequencer;

  logic        master_clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0;
  logic [15:0] cfg_num_blocks = '0, cfg_packets = '0;
  logic        cfg_raw_mode = 1'b0;
  logic [31:0] cfg_pulse_period = '0, cfg_pulse_high = '0, cfg_timeout = '0;
  logic        mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic        acq_resetn, acq_send_raw, busy, done, cfg_err, timeout_err;
  logic [15:0] acq_number_of_packet, block_count;
  logic [31:0] acq_pulse_period, acq_pulse_high;
  logic [2:0]  state;

  int compared = 0;
  int mismatched = 0;

  acq_sequencer #(.ARM_CYCLES(4), .DRAIN_CYCLES(20)) dut (
    .master_clock(master_clock), .reset(reset),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_num_blocks(cfg_num_blocks), .cfg_packets(cfg_packets), .cfg_raw_mode(cfg_raw_mode),
    .cfg_pulse_period(cfg_pulse_period), .cfg_pulse_high(cfg_pulse_high), .cfg_timeout(cfg_timeout),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .acq_resetn(acq_resetn), .acq_number_of_packet(acq_number_of_packet), .acq_send_raw(acq_send_raw),
    .acq_pulse_period(acq_pulse_period), .acq_pulse_high(acq_pulse_high),
    .busy(busy), .done(done), .cfg_err(cfg_err), .timeout_err(timeout_err),
    .block_count(block_count), .state(state)
  );

  always #12.5 master_clock = ~master_clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge master_clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input logic v, input logic r, input logic l);
    mon_tvalid = v;
    mon_tready = r;
    mon_tlast  = l;
  endtask

  // Start pulse, then walk the 4 ARM cycles so the bench sits in RUN cycle 1.
  task automatic start_to_run();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick(4);
  endtask

  initial begin
    cfg_pulse_period = 32'd77;
    cfg_packets      = 16'hBEEF;
    tick(2);
    reset = 1'b0;
    check("rst_state", state, 3'd0);
    check("rst_resetn", acq_resetn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", block_count, 16'd0);
    check("rst_period", acq_pulse_period, 32'd0);

    // Invalid pulse configs and start+stop collision: nothing latched.
    cfg_pulse_period = 32'd400; cfg_pulse_high = 32'd0;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("bad_high_err", cfg_err, 1'b1);
    check("bad_high_state", state, 3'd0);
    check("bad_high_acq", acq_pulse_period, 32'd0);
    tick();
    check("bad_high_err_pulse", cfg_err, 1'b0);
    cfg_pulse_period = 32'd40; cfg_pulse_high = 32'd40;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("eq_period_err", cfg_err, 1'b1);
    cfg_pulse_period = 32'd400;
    cmd_start = 1'b1; cmd_stop = 1'b1; tick(); cmd_start = 1'b0; cmd_stop = 1'b0;
    check("startstop_state", state, 3'd0);
    check("startstop_err", cfg_err, 1'b0);
    check("startstop_acq", acq_pulse_high, 32'd0);

    // Two-block run.
    cfg_num_blocks = 16'd2; cfg_packets = 16'h0123; cfg_raw_mode = 1'b1; cfg_timeout = 32'd0;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("arm_state", state, 3'd1);
    check("arm_busy", busy, 1'b1);
    check("arm_resetn", acq_resetn, 1'b0);
    check("arm_period", acq_pulse_period, 32'd400);
    check("arm_high", acq_pulse_high, 32'd40);
    check("arm_packets", acq_number_of_packet, 16'h0123);
    check("arm_raw", acq_send_raw, 1'b1);
    tick(3);
    check("arm_last_state", state, 3'd1);
    check("arm_last_resetn", acq_resetn, 1'b0);
    tick();
    check("run_state", state, 3'd2);
    check("run_resetn", acq_resetn, 1'b1);
    set_beat(1, 1, 1); tick();
    check("blk1_count", block_count, 16'd1);
    check("blk1_state", state, 3'd2);
    set_beat(1, 0, 1); tick();
    check("noready_count", block_count, 16'd1);
    set_beat(1, 1, 0); tick();
    check("nolast_count", block_count, 16'd1);
    set_beat(1, 1, 1); tick(); set_beat(0, 0, 0);
    check("blk2_state", state, 3'd4);
    check("blk2_done", done, 1'b1);
    check("blk2_count", block_count, 16'd2);
    check("blk2_resetn", acq_resetn, 1'b0);
    check("blk2_busy", busy, 1'b0);
    tick();
    check("after_done_state", state, 3'd0);
    check("after_done_pulse", done, 1'b0);

    // Watchdog, including a beat landing on the expiry cycle.
    cfg_num_blocks = 16'd0; cfg_timeout = 32'd100;
    start_to_run();
    tick(99);
    check("wd_c100_state", state, 3'd2);
    set_beat(1, 1, 0); tick(); set_beat(0, 0, 0);
    check("wd_beat_state", state, 3'd2);
    check("wd_beat_err", timeout_err, 1'b0);
    tick(99);
    check("wd_c200_state", state, 3'd2);
    tick();
    check("wd_err_state", state, 3'd5);
    check("wd_err_flag", timeout_err, 1'b1);
    check("wd_err_resetn", acq_resetn, 1'b0);
    check("wd_err_busy", busy, 1'b0);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("err_start_ignored", state, 3'd5);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    check("err_stop_state", state, 3'd0);
    check("err_sticky", timeout_err, 1'b1);
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("restart_clears_err", timeout_err, 1'b0);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    check("arm_stop_state", state, 3'd4);
    check("arm_stop_done", done, 1'b1);
    tick();
    check("arm_stop_idle", state, 3'd0);

    // Continuous run, stop, closing tlast 10 cycles later.
    cfg_timeout = 32'd0;
    start_to_run();
    set_beat(1, 1, 1); tick(); set_beat(0, 0, 0);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    check("drain_state", state, 3'd3);
    check("drain_resetn", acq_resetn, 1'b1);
    tick(9);
    check("drain_c10_state", state, 3'd3);
    set_beat(1, 1, 1); tick(); set_beat(0, 0, 0);
    check("drain_tlast_state", state, 3'd4);
    check("drain_tlast_done", done, 1'b1);
    check("drain_tlast_count", block_count, 16'd2);
    tick();

    // Drain expiring without a closing tlast.
    start_to_run();
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    tick(19);
    check("drain_c20_state", state, 3'd3);
    tick();
    check("drain_exp_state", state, 3'd4);
    check("drain_exp_count", block_count, 16'd0);
    tick();

    // Stop coincident with the completing tlast.
    cfg_num_blocks = 16'd1;
    start_to_run();
    set_beat(1, 1, 1); cmd_stop = 1'b1; tick(); set_beat(0, 0, 0); cmd_stop = 1'b0;
    check("coinc_state", state, 3'd4);
    check("coinc_count", block_count, 16'd1);
    tick();

    // Mid-run config changes are ignored; reset mid-run clears everything.
    cfg_num_blocks = 16'd0;
    start_to_run();
    set_beat(1, 1, 1); tick(5); set_beat(0, 0, 0);
    cfg_pulse_period = 32'd999; cfg_pulse_high = 32'd9; cfg_packets = 16'h7777; cfg_raw_mode = 1'b0;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("run_start_ignored", state, 3'd2);
    check("run_cfg_period", acq_pulse_period, 32'd400);
    check("run_cfg_high", acq_pulse_high, 32'd40);
    check("run_cfg_packets", acq_number_of_packet, 16'h0123);
    check("run_cfg_raw", acq_send_raw, 1'b1);
    check("run_count5", block_count, 16'd5);
    reset = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b1; set_beat(1, 1, 1);
    tick();
    reset = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; set_beat(0, 0, 0);
    check("mrst_state", state, 3'd0);
    check("mrst_resetn", acq_resetn, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_cfg_err", cfg_err, 1'b0);
    check("mrst_timeout_err", timeout_err, 1'b0);
    check("mrst_count", block_count, 16'd0);
    check("mrst_period", acq_pulse_period, 32'd0);
    check("mrst_high", acq_pulse_high, 32'd0);
    check("mrst_packets", acq_number_of_packet, 16'd0);
    check("mrst_raw", acq_send_raw, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
